// File: rtl/seq_combo_checker_pkg.sv
// Shared types and window-bound helpers for the composed-sequence checker.
// Lanes derive their own bounds from these helpers because the delays are per-instance parameters.
package seq_chk_pkg;

   typedef enum logic [1:0] {
      MODE_OR    = 2'd0,
      MODE_AND   = 2'd1,
      MODE_ISECT = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } lane_state_e;

   localparam int unsigned K_W = 8;

   function automatic int unsigned win_lo(input int unsigned bmin, input int unsigned cmin);
      return (bmin > cmin) ? bmin : cmin;
   endfunction

   function automatic int unsigned win_hi(input int unsigned bmax, input int unsigned cmax);
      return (bmax < cmax) ? bmax : cmax;
   endfunction

   function automatic int unsigned win_max(input int unsigned bmax, input int unsigned cmax);
      return (bmax > cmax) ? bmax : cmax;
   endfunction

   localparam int unsigned DEF_B_MIN = 1;
   localparam int unsigned DEF_B_MAX = 5;
   localparam int unsigned DEF_C_MIN = 1;
   localparam int unsigned DEF_C_MAX = 2;
   localparam int unsigned DEF_LO    = win_lo(DEF_B_MIN, DEF_C_MIN);
   localparam int unsigned DEF_HI    = win_hi(DEF_B_MAX, DEF_C_MAX);
   localparam int unsigned DEF_MAXW  = win_max(DEF_B_MAX, DEF_C_MAX);

endpackage

// File: rtl/seq_combo_checker_if.sv
// Monitor-side bundle: stimulus (mode/a/b/c) in, per-lane outcome pulses and counters out.
interface seq_combo_checker_if #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = 16
);
   logic [1:0]       mode;
   logic [NCH-1:0]   a;
   logic [NCH-1:0]   b;
   logic [NCH-1:0]   c;
   logic [NCH-1:0]   busy;
   logic [NCH-1:0]   match;
   logic [NCH-1:0]   fail;
   logic [NCH-1:0]   drop;
   logic             cfg_err;
   logic [CNT_W-1:0] match_cnt;
   logic [CNT_W-1:0] fail_cnt;

   modport master (
      output mode, a, b, c,
      input  busy, match, fail, drop, cfg_err, match_cnt, fail_cnt
   );

   modport slave (
      input  mode, a, b, c,
      output busy, match, fail, drop, cfg_err, match_cnt, fail_cnt
   );
endinterface

// File: rtl/seq_combo_checker_lane.sv
// One checker channel: IDLE/WAIT FSM, offset counter k, hit latches and registered outcome pulses.
module seq_chk_lane
   import seq_chk_pkg::*;
#(
   parameter int unsigned B_MIN = 1,
   parameter int unsigned B_MAX = 5,
   parameter int unsigned C_MIN = 1,
   parameter int unsigned C_MAX = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rose,
   input  logic [1:0] i_mode,
   input  logic       i_b,
   input  logic       i_c,
   output logic       o_busy,
   output logic       o_match,
   output logic       o_fail,
   output logic       o_drop,
   output logic       o_cfg_err
);

   localparam int unsigned LO   = win_lo(B_MIN, C_MIN);
   localparam int unsigned HI   = win_hi(B_MAX, C_MAX);
   localparam int unsigned MAXW = win_max(B_MAX, C_MAX);
   localparam bit          ISECT_EMPTY = (LO > HI);

   localparam logic [K_W-1:0] KB_MIN = K_W'(B_MIN);
   localparam logic [K_W-1:0] KB_MAX = K_W'(B_MAX);
   localparam logic [K_W-1:0] KC_MIN = K_W'(C_MIN);
   localparam logic [K_W-1:0] KC_MAX = K_W'(C_MAX);
   localparam logic [K_W-1:0] K_LO   = K_W'(LO);
   localparam logic [K_W-1:0] K_HI   = K_W'(HI);
   localparam logic [K_W-1:0] K_MAXW = K_W'(MAXW);

   lane_state_e    r_state;
   mode_e          r_mode;
   logic [K_W-1:0] r_k;
   logic           r_b_hit, r_c_hit;
   logic           r_busy, r_match, r_fail, r_drop, r_cfg;

   logic w_bh, w_ch, w_bl, w_cl, w_match_now, w_fail_now;

   always_comb begin
      w_bh        = i_b && (r_k >= KB_MIN) && (r_k <= KB_MAX);
      w_ch        = i_c && (r_k >= KC_MIN) && (r_k <= KC_MAX);
      w_bl        = r_b_hit | w_bh;
      w_cl        = r_c_hit | w_ch;
      w_match_now = 1'b0;
      w_fail_now  = 1'b0;
      // match is resolved first in every mode so the two outcomes stay exclusive
      case (r_mode)
         MODE_OR: begin
            if (w_bl || w_cl)         w_match_now = 1'b1;
            else if (r_k == K_MAXW)   w_fail_now  = 1'b1;
         end
         MODE_AND: begin
            if (w_bl && w_cl)         w_match_now = 1'b1;
            else if ((r_k == KB_MAX && !w_bl) || (r_k == KC_MAX && !w_cl))
                                      w_fail_now  = 1'b1;
         end
         MODE_ISECT: begin
            if (ISECT_EMPTY)          w_fail_now  = 1'b1;
            else if (i_b && i_c && (r_k >= K_LO) && (r_k <= K_HI))
                                      w_match_now = 1'b1;
            else if (r_k == K_HI)     w_fail_now  = 1'b1;
         end
         default:                     w_fail_now  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_mode  <= MODE_OR;
         r_k     <= '0;
         r_b_hit <= 1'b0;
         r_c_hit <= 1'b0;
         r_busy  <= 1'b0;
         r_match <= 1'b0;
         r_fail  <= 1'b0;
         r_drop  <= 1'b0;
         r_cfg   <= 1'b0;
      end else begin
         r_match <= 1'b0;
         r_fail  <= 1'b0;
         r_drop  <= 1'b0;
         r_cfg   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_rose) begin
                  if (mode_e'(i_mode) == MODE_RSVD) begin
                     r_cfg <= 1'b1;
                  end else begin
                     r_state <= WAIT;
                     r_mode  <= mode_e'(i_mode);
                     r_k     <= K_W'(1);
                     r_b_hit <= 1'b0;
                     r_c_hit <= 1'b0;
                     r_busy  <= 1'b1;
                  end
               end
            end
            WAIT: begin
               r_drop <= i_rose;
               if (w_match_now || w_fail_now) begin
                  r_match <= w_match_now;
                  r_fail  <= w_fail_now & ~w_match_now;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_b_hit <= w_bl;
                  r_c_hit <= w_cl;
                  if (r_k != '1) r_k <= r_k + K_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_match   = r_match;
   assign o_fail    = r_fail;
   assign o_drop    = r_drop;
   assign o_cfg_err = r_cfg;

endmodule

// File: rtl/seq_combo_checker.sv
// Multi-channel composed-sequence checker: rise detect, NCH independent lanes,
// cfg_err aggregation and saturating match/fail totals.
module seq_combo_checker
   import seq_chk_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned B_MIN = DEF_B_MIN,
   parameter int unsigned B_MAX = DEF_B_MAX,
   parameter int unsigned C_MIN = DEF_C_MIN,
   parameter int unsigned C_MAX = DEF_C_MAX,
   parameter int unsigned CNT_W = 16
) (
   input logic               clk,
   input logic               rst,
   seq_combo_checker_if.slave bus
);

   localparam int unsigned SUM_W = CNT_W + $clog2(NCH + 1);

   logic [NCH-1:0]   r_a_q;
   logic [NCH-1:0]   w_rose, w_busy, w_match, w_fail, w_drop, w_cfg;
   logic [CNT_W-1:0] r_match_cnt, r_fail_cnt;
   logic [SUM_W-1:0] w_msum, w_fsum;

   always_ff @(posedge clk) begin
      if (rst) r_a_q <= '0;
      else     r_a_q <= bus.a;
   end

   assign w_rose = bus.a & ~r_a_q;

   for (genvar g = 0; g < NCH; g++) begin : g_lane
      seq_chk_lane #(
         .B_MIN(B_MIN),
         .B_MAX(B_MAX),
         .C_MIN(C_MIN),
         .C_MAX(C_MAX)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .i_rose   (w_rose[g]),
         .i_mode   (bus.mode),
         .i_b      (bus.b[g]),
         .i_c      (bus.c[g]),
         .o_busy   (w_busy[g]),
         .o_match  (w_match[g]),
         .o_fail   (w_fail[g]),
         .o_drop   (w_drop[g]),
         .o_cfg_err(w_cfg[g])
      );
   end

   always_comb begin
      w_msum = SUM_W'(r_match_cnt);
      w_fsum = SUM_W'(r_fail_cnt);
      for (int unsigned i = 0; i < NCH; i++) begin
         w_msum = w_msum + SUM_W'(w_match[i]);
         w_fsum = w_fsum + SUM_W'(w_fail[i]);
      end
   end

   // any carry above CNT_W means the total has reached the ceiling
   always_ff @(posedge clk) begin
      if (rst) begin
         r_match_cnt <= '0;
         r_fail_cnt  <= '0;
      end else begin
         r_match_cnt <= (w_msum[SUM_W-1:CNT_W] != '0) ? '1 : w_msum[CNT_W-1:0];
         r_fail_cnt  <= (w_fsum[SUM_W-1:CNT_W] != '0) ? '1 : w_fsum[CNT_W-1:0];
      end
   end

   assign bus.busy      = w_busy;
   assign bus.match     = w_match;
   assign bus.fail      = w_fail;
   assign bus.drop      = w_drop;
   assign bus.cfg_err   = |w_cfg;
   assign bus.match_cnt = r_match_cnt;
   assign bus.fail_cnt  = r_fail_cnt;

endmodule
